// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: size codes, FSM states
// and default bus widths.
package mem_bus_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   localparam logic [2:0] SZ_BYTE = 3'd0;
   localparam logic [2:0] SZ_HALF = 3'd1;
   localparam logic [2:0] SZ_WORD = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin encoder: picks the lowest requesting index at or
// above prio, wrapping around, and reports it one-hot and as an index.
module rr_pick #(
   parameter int NM = 2
) (
   input  logic [NM-1:0]         req,
   input  logic [$clog2(NM)-1:0] prio,
   output logic [NM-1:0]         gnt,
   output logic [$clog2(NM)-1:0] idx
);

   localparam int IW = $clog2(NM);

   logic [IW-1:0] cand;

   // Walk from the farthest offset down to prio so the nearest requester wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      cand = '0;
      for (int k = NM - 1; k >= 0; k--) begin
         cand = IW'((int'(prio) + k) % NM);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter sharing one memory-bus slave between NM kernel masters.
// One transaction at a time: IDLE grants, BUSY waits for s_ready, DONE pulses m_ready.
module mem_bus_arb
   import mem_bus_pkg::*;
#(
   parameter int NM = 2,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NM-1:0]         m_valid,
   input  logic [NM-1:0]         m_write,
   input  logic [3*NM-1:0]       m_size,
   input  logic [AW*NM-1:0]      m_addr,
   input  logic [DW*NM-1:0]      m_wdata,
   output logic [NM-1:0]         m_ready,
   output logic [DW-1:0]         m_rdata,
   output logic                  s_valid,
   output logic                  s_write,
   output logic [2:0]            s_size,
   output logic [AW-1:0]         s_addr,
   output logic [DW-1:0]         s_wdata,
   input  logic [DW-1:0]         s_rdata,
   input  logic                  s_ready,
   output logic [$clog2(NM)-1:0] owner,
   output logic                  busy
);

   localparam int IW = $clog2(NM);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] prio_q, prio_d;
   logic [IW-1:0] owner_q, owner_d;
   logic          s_valid_q, s_valid_d;
   logic          s_write_q, s_write_d;
   logic [2:0]    s_size_q, s_size_d;
   logic [AW-1:0] s_addr_q, s_addr_d;
   logic [DW-1:0] s_wdata_q, s_wdata_d;
   logic [NM-1:0] m_ready_q, m_ready_d;
   logic [DW-1:0] m_rdata_q, m_rdata_d;

   logic [NM-1:0] pick_gnt;
   logic [IW-1:0] pick_idx;

   rr_pick #(.NM(NM)) u_pick (
      .req  (m_valid),
      .prio (prio_q),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      s_valid_d = s_valid_q;
      s_write_d = s_write_q;
      s_size_d  = s_size_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      m_ready_d = '0;
      m_rdata_d = m_rdata_q;
      case (state_q)
         IDLE: begin
            if (|m_valid) begin
               owner_d   = pick_idx;
               s_write_d = |(m_write & pick_gnt);
               s_size_d  = m_size[3*int'(pick_idx) +: 3];
               s_addr_d  = m_addr[AW*int'(pick_idx) +: AW];
               s_wdata_d = m_wdata[DW*int'(pick_idx) +: DW];
               s_valid_d = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            // s_ready is only honoured here; the slave's lingering ready in DONE/IDLE is dropped.
            if (s_ready) begin
               m_rdata_d          = s_rdata;
               m_ready_d          = '0;
               m_ready_d[owner_q] = 1'b1;
               s_valid_d          = 1'b0;
               state_d            = DONE;
            end
         end
         DONE: begin
            prio_d  = (owner_q == IW'(NM - 1)) ? '0 : owner_q + IW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         prio_q    <= '0;
         owner_q   <= '0;
         s_valid_q <= 1'b0;
         s_write_q <= 1'b0;
         s_size_q  <= SZ_BYTE;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         m_ready_q <= '0;
         m_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         owner_q   <= owner_d;
         s_valid_q <= s_valid_d;
         s_write_q <= s_write_d;
         s_size_q  <= s_size_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         m_ready_q <= m_ready_d;
         m_rdata_q <= m_rdata_d;
      end
   end

   assign owner   = owner_q;
   assign busy    = (state_q != IDLE);
   assign s_valid = s_valid_q;
   assign s_write = s_write_q;
   assign s_size  = s_size_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign m_ready = m_ready_q;
   assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed scenarios plus random traffic against a
// transaction-level model (grant by round-robin rule, timing by latency rules).
module tb_mem_bus_arb;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM-1:0]     m_valid, m_write, m_ready;
   logic [3*NM-1:0]   m_size;
   logic [AW*NM-1:0]  m_addr;
   logic [DW*NM-1:0]  m_wdata;
   logic [DW-1:0]     m_rdata, s_wdata, s_rdata;
   logic              s_valid, s_write, s_ready, busy;
   logic [2:0]        s_size;
   logic [AW-1:0]     s_addr;
   logic [0:0]        owner;

   always #5 clk = ~clk;

   mem_bus_arb #(.NM(NM), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_write(m_write), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_write(s_write), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .owner(owner), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // master side
   bit            pend[NM];
   logic          mw[NM];
   logic [2:0]    msz[NM];
   logic [AW-1:0] ma[NM];
   logic [DW-1:0] md[NM];
   int            mode;        // 0 random, 1 continuous, 2 directed only

   // slave side
   int slv_wait;
   int wcnt;
   bit force_rdy;

   // reference model
   int cyc;
   bit in_txn, acked, gp;
   int ack_cyc, free_from, prio_m, last_owner;
   int t_m, g_m;
   logic t_w, g_w;
   logic [2:0] t_sz, g_sz;
   logic [AW-1:0] t_a, g_a;
   logic [DW-1:0] t_d, g_d;
   int pulse_q[$];
   int pcyc_q[$];
   int pown_q[$];

   function automatic logic [31:0] rfun(input logic [31:0] a);
      return (a == 32'h0000_1100) ? 32'h7469_6873 : (a ^ 32'hA5A5_0000);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_m();
      for (int i = 0; i < NM; i++) begin
         m_valid[i]           = pend[i];
         m_write[i]           = mw[i];
         m_size[3*i +: 3]     = msz[i];
         m_addr[AW*i +: AW]   = ma[i];
         m_wdata[DW*i +: DW]  = md[i];
      end
   endtask

   task automatic set_req(input int i, input logic w, input logic [2:0] sz,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1'b1; mw[i] = w; msz[i] = sz; ma[i] = a; md[i] = d;
      drive_m();
   endtask

   task automatic new_req(input int i);
      set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), $urandom, $urandom);
   endtask

   // Grant rule: first requester at or above prio, wrapping; only once the bus is free.
   task automatic model_arbitrate();
      if (!in_txn && !gp && cyc >= free_from) begin
         for (int k = 0; k < NM; k++) begin
            int c;
            c = (prio_m + k) % NM;
            if (!gp && pend[c]) begin
               gp = 1'b1; g_m = c; g_w = mw[c]; g_sz = msz[c]; g_a = ma[c]; g_d = md[c];
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [NM-1:0] exp_mr;
      bit exp_sv;
      if (gp) begin
         gp = 1'b0; in_txn = 1'b1; acked = 1'b0; last_owner = g_m;
         t_m = g_m; t_w = g_w; t_sz = g_sz; t_a = g_a; t_d = g_d;
      end
      exp_sv = in_txn && !acked;
      exp_mr = '0;
      if (in_txn && acked && cyc == ack_cyc + 1) exp_mr[t_m] = 1'b1;
      chk("s_valid", s_valid, exp_sv);
      chk("busy", busy, in_txn);
      chk("m_ready", m_ready, exp_mr);
      chk("owner", owner, last_owner);
      if (exp_sv) begin
         chk("s_write", s_write, t_w);
         chk("s_size", s_size, t_sz);
         chk("s_addr", s_addr, t_a);
         chk("s_wdata", s_wdata, t_d);
      end
      if (exp_mr != '0) begin
         chk("m_rdata", m_rdata, rfun(t_a));
         in_txn = 1'b0;
         free_from = cyc + 1;
         prio_m = (t_m + 1) % NM;
      end
      for (int i = 0; i < NM; i++)
         if (m_ready[i] === 1'b1) begin
            pulse_q.push_back(i); pcyc_q.push_back(cyc); pown_q.push_back(int'(owner));
         end
   endtask

   task automatic update_masters();
      for (int i = 0; i < NM; i++) begin
         if (m_ready[i] === 1'b1) begin
            pend[i] = 1'b0;
            if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) new_req(i);
         end else if (!pend[i] && mode == 0 && $urandom_range(0, 3) == 0) begin
            new_req(i);
         end
      end
      drive_m();
   endtask

   task automatic step();
      logic prev_sv;
      prev_sv = s_valid;
      @(posedge clk); #1; cyc++;
      check_outputs();
      // registered slave: ready follows valid after slv_wait extra cycles
      if (prev_sv) wcnt++; else wcnt = 0;
      s_ready = force_rdy || (prev_sv && wcnt > slv_wait);
      s_rdata = rfun(s_addr);
      if (in_txn && !acked && s_ready) begin acked = 1'b1; ack_cyc = cyc; end
      update_masters();
      model_arbitrate();
   endtask

   task automatic apply_reset(input int hold);
      rst = 1'b1;
      #1;
      chk("rst_s_valid", s_valid, 0);
      chk("rst_s_write", s_write, 0);
      chk("rst_s_size", s_size, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_s_wdata", s_wdata, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_m_rdata", m_rdata, 0);
      chk("rst_owner", owner, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < NM; i++) pend[i] = 1'b0;
      drive_m();
      repeat (hold) begin
         @(posedge clk); #1; cyc++;
         s_ready = force_rdy;
      end
      rst = 1'b0;
      in_txn = 1'b0; acked = 1'b0; gp = 1'b0;
      prio_m = 0; last_owner = 0; free_from = cyc;
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int target;
      int t;
      target = pulse_q.size() + n;
      t = 0;
      while (pulse_q.size() < target && t < budget) begin step(); t++; end
      chk("pulse_budget", pulse_q.size() >= target, 1);
   endtask

   task automatic drain(input int budget);
      int t;
      bit any;
      t = 0;
      any = 1'b1;
      while (any && t < budget) begin
         step(); t++;
         any = in_txn || gp;
         for (int i = 0; i < NM; i++) any = any || pend[i];
      end
      chk("drain_budget", any, 0);
   endtask

   initial begin
      int rc, s;
      rst = 1'b1; s_ready = 1'b0; s_rdata = '0; force_rdy = 1'b0;
      slv_wait = 0; wcnt = 0; mode = 2; cyc = 0;
      for (int i = 0; i < NM; i++) begin
         pend[i] = 1'b0; mw[i] = 1'b0; msz[i] = '0; ma[i] = '0; md[i] = '0;
      end
      drive_m();
      @(posedge clk); #1;
      apply_reset(2);

      // single read of "shit" by m0
      rc = cyc;
      set_req(0, 1'b0, 3'd2, 32'h0000_1100, '0);
      model_arbitrate();
      step();
      chk("rd_svalid_next", s_valid, 1);
      wait_pulses(1, 20);
      chk("rd_latency", pcyc_q[$] - rc, 3);
      chk("rd_who", pulse_q[$], 0);
      chk("rd_data", m_rdata, 32'h7469_6873);
      drain(20);

      // simultaneous requests from prio 0
      apply_reset(1);
      set_req(0, 1'b0, 3'd2, 32'h0000_2000, '0);
      set_req(1, 1'b0, 3'd1, 32'h0000_3002, '0);
      model_arbitrate();
      s = pulse_q.size();
      wait_pulses(2, 40);
      chk("sim_first", pulse_q[s], 0);
      chk("sim_second", pulse_q[s+1], 1);
      chk("sim_owner0", pown_q[s], 0);
      chk("sim_owner1", pown_q[s+1], 1);
      drain(20);

      // continuous requests alternate
      mode = 1;
      new_req(0); new_req(1);
      model_arbitrate();
      s = pulse_q.size();
      wait_pulses(8, 100);
      for (int k = 1; k < 8; k++) chk("fair_alt", pulse_q[s+k], 1 - pulse_q[s+k-1]);
      mode = 2;
      drain(40);

      // slave with 4 wait states
      slv_wait = 4;
      mode = 1;
      new_req(0); new_req(1);
      model_arbitrate();
      wait_pulses(4, 100);
      mode = 2;
      drain(60);
      slv_wait = 0;

      // writes of each size from m1 to an unaligned address
      for (int sz = 0; sz < 3; sz++) begin
         set_req(1, 1'b1, 3'(sz), 32'h0000_1203, $urandom);
         model_arbitrate();
         wait_pulses(1, 30);
         chk("wr_who", pulse_q[$], 1);
      end
      drain(20);

      // reset in BUSY, late s_ready, then grant restarts from prio 0
      set_req(0, 1'b0, 3'd2, 32'h0000_0040, '0);
      model_arbitrate();
      wait_pulses(1, 20);
      drain(20);
      slv_wait = 4;
      set_req(0, 1'b0, 3'd2, 32'h0000_0080, '0);
      model_arbitrate();
      step(); step();
      chk("pre_rst_busy", busy, 1);
      force_rdy = 1'b1;
      apply_reset(1);
      step();
      chk("late_rdy_no_mready", m_ready, 0);
      force_rdy = 1'b0;
      slv_wait = 0;
      set_req(0, 1'b0, 3'd0, 32'h0000_0011, '0);
      set_req(1, 1'b0, 3'd0, 32'h0000_0022, '0);
      model_arbitrate();
      s = pulse_q.size();
      wait_pulses(2, 40);
      chk("post_rst_first", pulse_q[s], 0);
      drain(20);

      // random traffic with varying slave latency
      mode = 0;
      for (int b = 0; b < 6; b++) begin
         slv_wait = $urandom_range(0, 3);
         repeat (60) step();
      end
      mode = 2;
      drain(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
